// File: rtl/mem_interface_if.sv
// Bus bundle between the control unit / word RAM and the memory interface stage.
interface mem_interface_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
);
   logic [DATA_WIDTH-1:0] BusMuxOut;
   logic                  MARin;
   logic                  MDRin;
   logic                  MDRout;
   logic                  mem_rd;
   logic                  mem_wr;
   logic                  busy;
   logic                  mem_done;
   logic                  mem_err;
   logic [DATA_WIDTH-1:0] BusMuxIn_MDR;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic                  ram_we;
   logic                  ram_req;
   logic                  ram_ack;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // master: control unit plus RAM model; slave: the memory interface stage
   modport master (
      output BusMuxOut, MARin, MDRin, MDRout, mem_rd, mem_wr, ram_ack, ram_rdata,
      input  busy, mem_done, mem_err, BusMuxIn_MDR, ram_addr, ram_wdata, ram_we, ram_req
   );

   modport slave (
      input  BusMuxOut, MARin, MDRin, MDRout, mem_rd, mem_wr, ram_ack, ram_rdata,
      output busy, mem_done, mem_err, BusMuxIn_MDR, ram_addr, ram_wdata, ram_we, ram_req
   );
endinterface

// File: rtl/mem_interface.sv
// MAR/MDR holder running a request/ack handshake with a word RAM, with a
// bounded wait that aborts with mem_err when the RAM never acknowledges.
module mem_interface #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int TIMEOUT    = 15
) (
   input logic            clock,
   input logic            clear,
   mem_interface_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] mar_reg, mar_next;
   logic [DATA_WIDTH-1:0] mdr_reg, mdr_next;
   logic [7:0]            cnt_reg, cnt_next;
   logic                  req_reg, req_next;
   logic                  we_reg, we_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
   logic                  done_reg, done_next;
   logic                  err_reg, err_next;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_reg <= IDLE;
         mar_reg   <= '0;
         mdr_reg   <= '0;
         cnt_reg   <= '0;
         req_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         mar_reg   <= mar_next;
         mdr_reg   <= mdr_next;
         cnt_reg   <= cnt_next;
         req_reg   <= req_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      mar_next   = mar_reg;
      mdr_next   = mdr_reg;
      cnt_next   = cnt_reg;
      req_next   = req_reg;
      we_next    = we_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.MARin) mar_next = bus.BusMuxOut[ADDR_WIDTH-1:0];
            if (bus.MDRin) mdr_next = bus.BusMuxOut;
            // the transaction launches with the pre-edge MAR/MDR, not a same-cycle load
            if (bus.mem_rd || bus.mem_wr) begin
               state_next = bus.mem_rd ? RD_WAIT : WR_WAIT;
               req_next   = 1'b1;
               we_next    = !bus.mem_rd;
               addr_next  = mar_reg;
               wdata_next = mdr_reg;
               cnt_next   = '0;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (bus.ram_ack) begin
               if (state_reg == RD_WAIT) mdr_next = bus.ram_rdata;
               req_next   = 1'b0;
               we_next    = 1'b0;
               done_next  = 1'b1;
               state_next = IDLE;
            end else if (cnt_reg == CNT_LAST) begin
               req_next   = 1'b0;
               we_next    = 1'b0;
               done_next  = 1'b1;
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.busy      = (state_reg != IDLE);
   assign bus.mem_done  = done_reg;
   assign bus.mem_err   = err_reg;
   assign bus.ram_addr  = addr_reg;
   assign bus.ram_wdata = wdata_reg;
   assign bus.ram_we    = we_reg;
   assign bus.ram_req   = req_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mdr_gate
         assign bus.BusMuxIn_MDR[gi] = mdr_reg[gi] & bus.MDRout;
      end
   endgenerate
endmodule

// File: doc/mem_interface.md
# mem_interface

Memory interface stage that feeds the datapath bus, and through it the general-purpose registers including R0. It holds the MAR and MDR and runs a multi-cycle read/write handshake with an external word RAM. It drives the MDR onto a gated bus input that the bus multiplexer consumes. The control unit loads the MAR/MDR from the bus, issues single-cycle read/write requests, and waits for `mem_done`.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 9, RAM address width; MAR holds BusMuxOut[ADDR_WIDTH-1:0]
- TIMEOUT, 15, maximum wait cycles for `ram_ack` before abort (range 1..255)

Ports:
- clock  in  1  single clock; all state changes on rising edge
- clear  in  1  reset, asynchronous and active-low
- BusMuxOut  in  DATA_WIDTH  datapath bus value
- MARin  in  1  load MAR from bus
- MDRin  in  1  load MDR from bus
- MDRout  in  1  gate MDR onto `BusMuxIn_MDR`
- mem_rd  in  1  read request: RAM[MAR] -> MDR
- mem_wr  in  1  write request: MDR -> RAM[MAR]
- busy  out  1  a transaction is in flight
- mem_done  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle pulse, coincident with `mem_done`, on timeout
- BusMuxIn_MDR  out  DATA_WIDTH  MDR when MDRout=1, else all zeros (combinational)
- ram_addr  out  ADDR_WIDTH  registered address, equals MAR during a transaction
- ram_wdata  out  DATA_WIDTH  registered write data, equals MDR during a write
- ram_we  out  1  write enable, valid while `ram_req`=1
- ram_req  out  1  request to RAM, held until ack or timeout
- ram_ack  in  1  RAM completion; read data is valid on `ram_rdata` in the same cycle
- ram_rdata  in  DATA_WIDTH  RAM read data

## Operation
- States:
  - IDLE: accepts requests and register loads.
  - RD_WAIT: read in flight.
  - WR_WAIT: write in flight.
- Transitions:
  - IDLE with `mem_rd`=1 -> RD_WAIT.
  - IDLE with `mem_wr`=1 and `mem_rd`=0 -> WR_WAIT.
  - If both requests are high, the read wins and the write is dropped, with no error.
- Entering a wait state, at the same edge:
  - `ram_req`=1 and `ram_addr`=MAR.
  - `ram_we` = 0 for a read, 1 for a write.
  - `ram_wdata`=MDR.
  - Wait counter is cleared to 0.
- RD_WAIT with `ram_ack`=1: MDR <= ram_rdata, `ram_req` and `ram_we` -> 0, `mem_done`=1 for the next cycle, state -> IDLE.
- WR_WAIT with `ram_ack`=1: same as the read case except MDR is unchanged.
- Wait state with `ram_ack`=0: counter increments.
- Timeout: if the counter equals TIMEOUT-1 and `ram_ack`=0, abort:
  - `ram_req`=0 and `ram_we`=0.
  - MDR unchanged.
  - `mem_done`=1 and `mem_err`=1 for one cycle.
  - State -> IDLE.
- Register loads:
  - MARin and MDRin are honoured only in IDLE. While busy they are ignored, so the address and write data stay stable.
  - A load in the same cycle as an accepted request takes effect, but the transaction uses the pre-edge MAR/MDR.
- `mem_rd`/`mem_wr` asserted while busy are ignored and not queued.
- `ram_ack` in IDLE is ignored.
- `busy` = (state != IDLE).
- `BusMuxIn_MDR[i]` = MDR[i] & MDRout for every bit i.

## Timing
- Reset (`clear`=0, asynchronous) forces:
  - state IDLE
  - MAR=0, MDR=0, counter=0
  - `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0
  - `mem_done`=0, `mem_err`=0, `busy`=0
  - `BusMuxIn_MDR`=0
- Reset mid-transaction aborts immediately with no `mem_done`. Release is synchronous to the next edge.
- Request accepted at edge k: `ram_req` and `busy` are high after edge k.
- Ack sampled at edge k+m (m ≥ 1):
  - MDR is updated after edge k+m.
  - `mem_done` is high during cycle k+m.
  - `busy` is low after edge k+m.
- Minimum request-to-done latency is 2 edges. A new request is accepted at edge k+m+1.
- Timeout: with no ack, `mem_done` and `mem_err` are high after edge k+TIMEOUT.
- `mem_done` and `mem_err` are always single-cycle pulses.

## Test plan
- Reset: drive `clear`=0 mid-RD_WAIT. Required: `ram_req`, `busy` and `mem_done` go to 0 immediately, MAR=MDR=0, and `BusMuxIn_MDR`=0 with MDRout=1.
- Read:
  - Stimulus: MARin with bus=0x0000_0105, then `mem_rd`; RAM acks 3 cycles later with 0xDEAD_BEEF.
  - Required: `ram_addr`=0x105 and `ram_we`=0; MDR=0xDEAD_BEEF; `BusMuxIn_MDR`=0xDEAD_BEEF only while MDRout=1.
  - Required: one-cycle `mem_done` with `mem_err`=0.
- Write with immediate ack:
  - Stimulus: MDRin with 0x1234_5678, MAR=0x0FF, `mem_wr`; ack at the first edge.
  - Required: `ram_we`=1 and `ram_wdata`=0x1234_5678 for exactly one cycle; `mem_done` 2 edges after the request.
- Timeout: TIMEOUT=4, read with `ram_ack` held at 0. Required: `mem_done`=`mem_err`=1 after the 4th edge, MDR unchanged, `busy`=0.
- Simultaneous/busy events:
  - `mem_rd` and `mem_wr` in the same cycle: required read only, `ram_we`=0.
  - MARin=0x0AA while busy: required `ram_addr` unchanged.
  - Second `mem_rd` while busy: required no extra `mem_done`.
- Stray ack: `ram_ack`=1 in IDLE. Required: no `mem_done` and MDR unchanged.
